// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the pipelined adder/subtractor.
package adder_pkg;

  // Operation select for the arithmetic core
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBC = 2'd3
  } op_t;

  // ARM-style condition flags, packed as {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_V  = 0;

  // Subtracting ops feed the inverted B operand
  function automatic logic is_sub(input op_t o);
    return (o == SUB) || (o == SBC);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: SEG-bit ripple-carry adder; one instance per pipeline stage.
module adder_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           ctop
);

  logic [SEG:0] cy;

  // Bit-serial full-adder chain
  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = cy[SEG];
  assign ctop = cy[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ADD/SUB/ADC/SBC with the carry chain split into
// STAGES registered segments and a stallable valid/ready handshake.
// Optional feature macro: ADDER_FLAGS_EN adds the registered {N,Z,C,V} flags port.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum
`ifdef ADDER_FLAGS_EN
  ,
  output flags_t           flags
`endif
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Reject configurations that cannot be split evenly
  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  logic             en;
  logic [WIDTH-1:0] bx;
  logic             c0;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] bx_in [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];

  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0] seg_ct;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];

  // Operand preparation: invert B and pick the initial carry
  always_comb begin
    bx = is_sub(op) ? ~b : b;
    c0 = carry_in;
    case (op)
      ADD:     c0 = 1'b0;
      SUB:     c0 = 1'b1;
      default: c0 = carry_in;
    endcase
  end

  // Stage inputs: stage 0 from the ports, later stages from the skewed registers
  always_comb begin
    a_in[0]  = a;
    bx_in[0] = bx;
    s_in[0]  = '0;
    c_in[0]  = c0;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_in[k]  = a_q[k-1];
      bx_in[k] = bx_q[k-1];
      s_in[k]  = s_q[k-1];
      c_in[k]  = c_q[k-1];
    end
  end

  // One ripple segment per stage, each working on its own slice
  generate
    for (genvar k = 0; k < int'(STAGES); k++) begin : g_seg
      adder_segment #(.SEG(SEG)) u_seg (
        .a    (a_in[k][k*SEG +: SEG]),
        .b    (bx_in[k][k*SEG +: SEG]),
        .cin  (c_in[k]),
        .sum  (seg_sum[k]),
        .cout (seg_co[k]),
        .ctop (seg_ct[k])
      );
    end
  endgenerate

  // Insert each stage's partial sum into the travelling result word
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      s_nxt[k]                = s_in[k];
      s_nxt[k][k*SEG +: SEG]  = seg_sum[k];
    end
  end

  // Pipeline registers: all stages advance together or hold together
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]  <= a_in[k];
        bx_q[k] <= bx_in[k];
        s_q[k]  <= s_nxt[k];
        c_q[k]  <= seg_co[k];
      end
    end
  end

`ifdef ADDER_FLAGS_EN
  flags_t flags_nxt;

  // Flags from the completed word; V uses the carry into and out of the MSB
  always_comb begin
    flags_nxt   = '0;
    flags_nxt.n = s_nxt[STAGES-1][WIDTH-1];
    flags_nxt.z = (s_nxt[STAGES-1] == '0);
    flags_nxt.c = seg_co[STAGES-1];
    flags_nxt.v = seg_ct[STAGES-1] ^ seg_co[STAGES-1];
  end

  // Flags register, advancing in lockstep with the final sum
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (en) begin
      flags <= flags_nxt;
    end
  end
`else
  logic unused_ct;
  assign unused_ct = ^seg_ct;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder
// (WIDTH=32, STAGES=4); flag checks are active when ADDER_FLAGS_EN is defined.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
`ifdef ADDER_FLAGS_EN
  flags_t           flags;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Streamed vectors with hand-computed results ({N,Z,C,V})
  op_t         s_op [8] = '{ADD, SUB, ADC, SBC, ADD, SUB, ADD, SBC};
  logic [31:0] s_a  [8] = '{32'h10, 32'h100, 32'hFFFFFFFF, 32'h0,
                            32'h80000000, 32'h80000000, 32'h12345678, 32'h10};
  logic [31:0] s_b  [8] = '{32'h20, 32'h1, 32'h0, 32'h0,
                            32'h80000000, 32'h1, 32'h11111111, 32'h1};
  logic        s_c  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] s_es [8] = '{32'h30, 32'hFF, 32'h0, 32'hFFFFFFFF,
                            32'h0, 32'h7FFFFFFF, 32'h23456789, 32'hF};
  logic [3:0]  s_ef [8] = '{4'b0000, 4'b0010, 4'b0110, 4'b1000,
                            4'b0111, 4'b0011, 4'b0000, 4'b0010};

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ADDER_FLAGS_EN
    .flags     (flags),
`endif
    .sum       (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] es, input logic [3:0] ef);
    chk({tag, " sum"}, 64'(sum), 64'(es));
`ifdef ADDER_FLAGS_EN
    chk({tag, " flags"}, 64'(flags), 64'(ef));
`else
    if (ef === 4'bxxxx) chk({tag, " flags arg"}, 64'(ef), 64'(4'b0000));
`endif
  endtask

  // Single op into an empty pipe: check latency, result and drain
  task automatic run_single(input string tag, input op_t o, input logic [31:0] x,
                            input logic [31:0] y, input logic ci,
                            input logic [31:0] es, input logic [3:0] ef);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    carry_in = ci;
    step();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, " early out_valid"}, 64'(out_valid), 64'(1'b0));
      step();
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'(1'b1));
    chk_res(tag, es, ef);
    step();
    chk({tag, " drained"}, 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    int tx;
    int rx;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = ADD;
    carry_in  = 1'b0;
    step();
    step();
    chk("reset out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset in_ready", 64'(in_ready), 64'(1'b1));
    chk_res("reset", 32'h0, 4'b0000);
    reset = 1'b0;
    step();

    run_single("add_wrap",   ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,        4'b0110);
    run_single("sub_5_7",    SUB, 32'h5,        32'h7, 1'b0, 32'hFFFFFFFE, 4'b1000);
    run_single("sub_7_5",    SUB, 32'h7,        32'h5, 1'b0, 32'h2,        4'b0010);
    run_single("add_ovf",    ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 4'b1001);
    run_single("sbc_ovf",    SBC, 32'h80000000, 32'h0, 1'b0, 32'h7FFFFFFF, 4'b0011);
    run_single("adc_cin",    ADC, 32'h1,        32'h1, 1'b1, 32'h3,        4'b0000);
    run_single("add_ignore", ADD, 32'h1,        32'h1, 1'b1, 32'h2,        4'b0000);

    // Back-to-back stream with a three-cycle consumer stall in cycles 5..7
    tx = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (tx < 8) begin
        in_valid = 1'b1;
        op       = s_op[tx];
        a        = s_a[tx];
        b        = s_b[tx];
        carry_in = s_c[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        chk("stall in_ready", 64'(in_ready), 64'(1'b0));
        chk("stall out_valid", 64'(out_valid), 64'(1'b1));
        chk_res("stall hold", s_es[rx], s_ef[rx]);
      end else begin
        chk("stream in_ready", 64'(in_ready), 64'(1'b1));
        if (c < 4) chk("stream fill out_valid", 64'(out_valid), 64'(1'b0));
        if (out_valid) begin
          chk_res("stream", s_es[rx], s_ef[rx]);
          rx++;
        end
      end
      if (in_valid && in_ready) tx++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream accepted", 64'(tx), 64'(8));
    chk("stream emitted", 64'(rx), 64'(8));
    step();
    chk("stream drained", 64'(out_valid), 64'(1'b0));

    // Reset with three ops in flight; the op presented during reset is dropped
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op       = ADD;
      a        = 32'(i + 1);
      b        = 32'h100;
      carry_in = 1'b0;
      step();
    end
    reset = 1'b1;
    a     = 32'h55;
    b     = 32'h55;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("post-reset out_valid", 64'(out_valid), 64'(1'b0));
    chk("post-reset in_ready", 64'(in_ready), 64'(1'b1));
    chk("post-reset sum", 64'(sum), 64'(0));
    for (int i = 0; i < 6; i++) begin
      chk("no stale result", 64'(out_valid), 64'(1'b0));
      step();
    end
    run_single("fresh", ADD, 32'h1000, 32'h0234, 1'b0, 32'h1234, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
